rr_mux_arbiter_4: RTL

RR_MUX_ARBITER_4 -- requirements
Module: rr_mux_arbiter_4

---
 rtl/rr_mux_arbiter_4.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter feeding a single registered output word.
// Grants rotate from the last winner; the output register reloads back-to-back when drained.
module rr_mux_arbiter_4 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  input  logic              out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_ptr;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_sel;

  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic                w_can_load;
  logic                w_load;
  logic [DATA_W-1:0]   w_mux;

  // Search order starts just past the last grant and ends on it.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_mux = in_data0;
    case (w_win)
      2'd0: w_mux = in_data0;
      2'd1: w_mux = in_data1;
      2'd2: w_mux = in_data2;
      2'd3: w_mux = in_data3;
    endcase
  end

  assign w_can_load = !rst && ((r_state == EMPTY) || out_ready);
  assign in_ready   = (w_found && w_can_load) ? (4'b0001 << w_win) : '0;
  assign w_load     = |in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_load) w_state_nxt = FULL;
      FULL:  if (out_ready && !w_load) w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= w_mux;
        r_sel  <= w_win;
        r_ptr  <= w_win;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
